// File: rtl/wb_arbiter_2to1.sv
// Two-master, one-slave pipelined Wishbone arbiter with round-robin grant held per cyc window.
// Responses reach only the owning master; an outstanding-request counter handles aborted cycles.
module wb_arbiter_2to1 #(
    parameter int AW    = 12,
    parameter int SL    = 4,
    parameter int OUT_W = 3
) (
    input  logic          cpu_clock_i,
    input  logic          cpu_rst_ni,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [31:0]   m0_dat_i,
    input  logic [SL-1:0] m0_sel_i,
    output logic          m0_stall_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    output logic [31:0]   m0_dat_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [31:0]   m1_dat_i,
    input  logic [SL-1:0] m1_sel_i,
    output logic          m1_stall_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic [31:0]   m1_dat_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [31:0]   s_dat_o,
    output logic [SL-1:0] s_sel_o,
    input  logic          s_stall_i,
    input  logic          s_ack_i,
    input  logic          s_err_i,
    input  logic [31:0]   s_dat_i
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [OUT_W-1:0] outst_q, outst_d;

    logic gnt0, gnt1, in_gnt, full, inc, resp;

    assign gnt0   = (state_q == GNT0) && m0_cyc_i;
    assign gnt1   = (state_q == GNT1) && m1_cyc_i;
    assign in_gnt = (state_q == GNT0) || (state_q == GNT1);
    assign full   = &outst_q;

    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = 1'b0;
        s_adr_o    = '0;
        s_dat_o    = '0;
        s_sel_o    = '0;
        m0_stall_o = 1'b1;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m0_dat_o   = '0;
        m1_stall_o = 1'b1;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        m1_dat_o   = '0;
        if (gnt0) begin
            s_cyc_o    = 1'b1;
            s_stb_o    = m0_stb_i & ~full;
            s_we_o     = m0_we_i;
            s_adr_o    = m0_adr_i;
            s_dat_o    = m0_dat_i;
            s_sel_o    = m0_sel_i;
            m0_stall_o = s_stall_i | full;
            m0_ack_o   = s_ack_i;
            m0_err_o   = s_err_i;
            m0_dat_o   = s_dat_i;
        end else if (gnt1) begin
            s_cyc_o    = 1'b1;
            s_stb_o    = m1_stb_i & ~full;
            s_we_o     = m1_we_i;
            s_adr_o    = m1_adr_i;
            s_dat_o    = m1_dat_i;
            s_sel_o    = m1_sel_i;
            m1_stall_o = s_stall_i | full;
            m1_ack_o   = s_ack_i;
            m1_err_o   = s_err_i;
            m1_dat_o   = s_dat_i;
        end
    end

    assign inc  = s_stb_o & ~s_stall_i;
    assign resp = in_gnt & (s_ack_i | s_err_i);

    // A response at zero is spurious: still forwarded, but never underflows the count.
    always_comb begin
        outst_d = outst_q;
        if (state_q == ABORT) begin
            outst_d = '0;
        end else if (inc && !resp) begin
            outst_d = outst_q + 1'b1;
        end else if (resp && !inc && (outst_q != '0)) begin
            outst_d = outst_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) state_d = last_q ? GNT0 : GNT1;
                else if (m0_cyc_i)        state_d = GNT0;
                else if (m1_cyc_i)        state_d = GNT1;
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    last_d = 1'b0;
                    if (outst_d != '0) state_d = ABORT;
                    else if (m1_cyc_i) state_d = GNT1;
                    else               state_d = IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    last_d = 1'b1;
                    if (outst_d != '0) state_d = ABORT;
                    else if (m0_cyc_i) state_d = GNT0;
                    else               state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge cpu_clock_i or negedge cpu_rst_ni) begin
        if (!cpu_rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            outst_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            outst_q <= outst_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Directed bench for wb_arbiter_2to1 (OUT_W=2) with an accepted-address scoreboard.
module tb_wb_arbiter_2to1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [11:0] m0_adr, m1_adr;
    logic [31:0] m0_wdat, m1_wdat;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_stall, m0_ack, m0_err, m1_stall, m1_ack, m1_err;
    logic [31:0] m0_rdat, m1_rdat;
    logic        s_cyc, s_stb, s_we;
    logic [11:0] s_adr;
    logic [31:0] s_wdat;
    logic [3:0]  s_sel;
    logic        s_stall, s_ack, s_err;
    logic [31:0] s_rdat;

    int n_checks = 0;
    int n_pass   = 0;
    logic [11:0] sb[$];

    always #5 clk = ~clk;

    wb_arbiter_2to1 #(.AW(12), .SL(4), .OUT_W(2)) dut (
        .cpu_clock_i(clk),      .cpu_rst_ni(rst_n),
        .m0_cyc_i(m0_cyc),      .m0_stb_i(m0_stb),     .m0_we_i(m0_we),
        .m0_adr_i(m0_adr),      .m0_dat_i(m0_wdat),    .m0_sel_i(m0_sel),
        .m0_stall_o(m0_stall),  .m0_ack_o(m0_ack),     .m0_err_o(m0_err),
        .m0_dat_o(m0_rdat),
        .m1_cyc_i(m1_cyc),      .m1_stb_i(m1_stb),     .m1_we_i(m1_we),
        .m1_adr_i(m1_adr),      .m1_dat_i(m1_wdat),    .m1_sel_i(m1_sel),
        .m1_stall_o(m1_stall),  .m1_ack_o(m1_ack),     .m1_err_o(m1_err),
        .m1_dat_o(m1_rdat),
        .s_cyc_o(s_cyc),        .s_stb_o(s_stb),       .s_we_o(s_we),
        .s_adr_o(s_adr),        .s_dat_o(s_wdat),      .s_sel_o(s_sel),
        .s_stall_i(s_stall),    .s_ack_i(s_ack),       .s_err_i(s_err),
        .s_dat_i(s_rdat)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every strobe the slave accepts must carry the next address the bench issued.
    always @(negedge clk) begin
        if (rst_n && s_stb && !s_stall) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                logic [11:0] e;
                e = sb.pop_front();
                check("sb_adr", 32'(s_adr), 32'(e));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = '0;
        m0_adr = '0; m1_adr = '0; m0_wdat = 32'h0A0A_0A0A; m1_wdat = 32'h0B0B_0B0B;
        m0_sel = 4'hF; m1_sel = 4'h3;
        {s_stall, s_ack, s_err} = '0;
        s_rdat = '0;

        // reset state
        #12;
        check("rst_m0_stall", 32'(m0_stall), 32'd1);
        check("rst_m1_stall", 32'(m1_stall), 32'd1);
        check("rst_s_cyc",    32'(s_cyc),    32'd0);
        check("rst_acks",     32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
        tick();
        rst_n = 1'b1;

        // single master m1 read
        tick();
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 12'h040; sb.push_back(12'h040);
        @(negedge clk);
        check("t1_arb_stall", 32'(m1_stall), 32'd1);
        check("t1_arb_s_stb", 32'(s_stb),    32'd0);
        tick();
        @(negedge clk);
        check("t1_s_adr",  32'(s_adr),  32'h040);
        check("t1_s_stb",  32'(s_stb),  32'd1);
        check("t1_s_sel",  32'(s_sel),  32'h3);
        tick();
        m1_stb = 1'b0; s_ack = 1'b1; s_rdat = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t1_m1_ack", 32'(m1_ack),  32'd1);
        check("t1_m1_dat", m1_rdat,      32'hDEAD_BEEF);
        check("t1_m0_ack", 32'(m0_ack),  32'd0);
        check("t1_m0_dat", m0_rdat,      32'd0);
        tick();
        s_ack = 1'b0; m1_cyc = 1'b0;
        tick();

        // simultaneous request: m0 wins the tie, m1 follows with no idle cycle
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 12'h010;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 12'h020;
        sb.push_back(12'h010); sb.push_back(12'h020);
        tick();
        @(negedge clk);
        check("t2_m0_gnt",   32'(m0_stall), 32'd0);
        check("t2_m1_wait",  32'(m1_stall), 32'd1);
        tick();
        m0_stb = 1'b0; s_ack = 1'b1; s_rdat = 32'h0000_1234;
        @(negedge clk);
        check("t2_m0_ack",   32'(m0_ack), 32'd1);
        check("t2_m1_noack", 32'(m1_ack), 32'd0);
        check("t2_m1_nodat", m1_rdat,     32'd0);
        tick();
        s_ack = 1'b0; m0_cyc = 1'b0;
        @(negedge clk);
        check("t2_drop_s_cyc", 32'(s_cyc), 32'd0);
        tick();
        @(negedge clk);
        check("t2_m1_gnt",   32'(m1_stall), 32'd0);
        check("t2_m1_adr",   32'(s_adr),    32'h020);
        tick();
        m1_stb = 1'b0; s_ack = 1'b1;
        tick();
        s_ack = 1'b0; m1_cyc = 1'b0;
        tick();

        // round-robin: both hold cyc, each owner releases once per window
        m0_cyc = 1'b1; m1_cyc = 1'b1;
        tick();
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            check($sformatf("rr%0d_own_stall", w),   32'((w % 2 == 0) ? m0_stall : m1_stall), 32'd0);
            check($sformatf("rr%0d_other_stall", w), 32'((w % 2 == 0) ? m1_stall : m0_stall), 32'd1);
            check($sformatf("rr%0d_s_cyc", w),       32'(s_cyc), 32'd1);
            tick();
            if (w % 2 == 0) m0_cyc = 1'b0; else m1_cyc = 1'b0;
            tick();
            if (w % 2 == 0) m0_cyc = 1'b1; else m1_cyc = 1'b1;
        end
        tick();
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        tick();

        // burst fill by m1 with slave stall; m0 waits until m1 drops cyc
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 12'h100; s_stall = 1'b1;
        sb.push_back(12'h100);
        tick();
        m0_cyc = 1'b1;
        @(negedge clk);
        check("t4_stall_c1", 32'(m1_stall),    32'd1);
        check("t4_outst_c1", 32'(dut.outst_q), 32'd0);
        tick();
        @(negedge clk);
        check("t4_stall_c2", 32'(m1_stall),    32'd1);
        tick();
        s_stall = 1'b0;
        @(negedge clk);
        check("t4_accept",   32'(m1_stall),    32'd0);
        tick();
        m1_adr = 12'h101; sb.push_back(12'h101);
        @(negedge clk);
        check("t4_outst_1",  32'(dut.outst_q), 32'd1);
        tick();
        m1_stb = 1'b0; s_ack = 1'b1; s_rdat = 32'h1111_0000;
        @(negedge clk);
        check("t4_outst_2",  32'(dut.outst_q), 32'd2);
        check("t4_m1_ack",   32'(m1_ack),      32'd1);
        check("t4_m0_stall", 32'(m0_stall),    32'd1);
        check("t4_m0_noack", 32'(m0_ack),      32'd0);
        tick();
        s_rdat = 32'h1111_0001;
        @(negedge clk);
        check("t4_outst_1b", 32'(dut.outst_q), 32'd1);
        check("t4_m1_dat",   m1_rdat,          32'h1111_0001);
        tick();
        s_ack = 1'b0; m1_cyc = 1'b0;
        @(negedge clk);
        check("t4_outst_0",  32'(dut.outst_q), 32'd0);
        check("t4_m0_hold",  32'(m0_stall),    32'd1);
        tick();
        @(negedge clk);
        check("t4_m0_gnt",   32'(m0_stall),    32'd0);

        // counter full (OUT_W=2: three outstanding maximum)
        for (int i = 0; i < 3; i++) begin
            tick();
            m0_stb = 1'b1; m0_adr = 12'h200 + 12'(i); sb.push_back(12'h200 + 12'(i));
        end
        tick();
        m0_adr = 12'h203; sb.push_back(12'h203);
        @(negedge clk);
        check("t5_full_stb",   32'(s_stb),    32'd0);
        check("t5_full_stall", 32'(m0_stall), 32'd1);
        check("t5_full_cnt",   32'(dut.outst_q), 32'd3);
        tick();
        s_ack = 1'b1;
        @(negedge clk);
        check("t5_ack_full_stb", 32'(s_stb), 32'd0);
        tick();
        s_ack = 1'b0;
        @(negedge clk);
        check("t5_reenable_stb",   32'(s_stb),    32'd1);
        check("t5_reenable_stall", 32'(m0_stall), 32'd0);

        // abort: m0 drops cyc with one request still outstanding
        tick();
        m0_stb = 1'b0; s_ack = 1'b1;
        tick();
        tick();
        s_ack = 1'b0; m0_cyc = 1'b0;
        @(negedge clk);
        check("t6_outst_1", 32'(dut.outst_q), 32'd1);
        tick();
        s_ack = 1'b1;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 12'h300; sb.push_back(12'h300);
        @(negedge clk);
        check("t6_abort_s_cyc", 32'(s_cyc),  32'd0);
        check("t6_abort_m0ack", 32'(m0_ack), 32'd0);
        check("t6_abort_m1ack", 32'(m1_ack), 32'd0);
        check("t6_abort_m1stl", 32'(m1_stall), 32'd1);
        tick();
        s_ack = 1'b0;
        @(negedge clk);
        check("t6_idle_outst", 32'(dut.outst_q), 32'd0);
        check("t6_idle_m1stl", 32'(m1_stall),    32'd1);
        tick();
        @(negedge clk);
        check("t6_m1_gnt",   32'(m1_stall), 32'd0);
        check("t6_m1_s_cyc", 32'(s_cyc),    32'd1);

        // asynchronous reset during GNT1
        #1;
        rst_n = 1'b0;
        #1;
        check("t7_rst_s_cyc",    32'(s_cyc),    32'd0);
        check("t7_rst_m1_stall", 32'(m1_stall), 32'd1);
        check("t7_rst_outst",    32'(dut.outst_q), 32'd0);
        m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
